// File: rtl/packet_eject_local_pkg.sv
// Shared definitions for the local eject sink:
// packet field offsets and the drain FSM state encoding.
package packet_eject_local_pkg;

  localparam int VALID_BIT = 48;
  localparam int TS_MSB    = 47;
  localparam int TS_LSB    = 32;
  localparam int SRC_MSB   = 31;
  localparam int SRC_LSB   = 16;
  localparam int DST_MSB   = 15;
  localparam int DST_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_POP  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/packet_eject_local_fifo.sv
// Circular eject FIFO: storage, wrapping pointers, occupancy count.
// Ports: push/pop strobes, wdata/rdata, count_next (post-update occupancy), full, empty.
module eject_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count_next,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Contents are not reset; the pointers make stale data unreachable.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata      = mem_q[rd_ptr_q];
  assign count_next = count_d;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/packet_eject_local.sv
// Local packet sink: buffers ejected packets, drains them at a bounded
// rate, and accumulates latency/error statistics. Ports: clk, rst,
// clk_counter, eject_in -> backpressure_wr, totals, max_latency, error/drop counts, done.
module packet_eject_local
  import packet_eject_local_pkg::*;
#(
  parameter int PACKET_SIZE      = 49,
  parameter int ROUTER_ID        = 0,
  parameter int BUFFER_SIZE      = 4,
  parameter int BUFFER_THRESHOLD = 1,
  parameter int DRAIN_CYCLE      = 2,
  parameter int EXPECTED_PACKETS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            clk_counter,
  input  logic [PACKET_SIZE-1:0] eject_in,
  output logic                   backpressure_wr,
  output logic [63:0]            total_packet_recieve,
  output logic [63:0]            total_latency,
  output logic [15:0]            max_latency,
  output logic [15:0]            dest_error_cnt,
  output logic [15:0]            drop_cnt,
  output logic                   done
);

  localparam int CW = $clog2(BUFFER_SIZE) + 1;
  localparam int GW = (DRAIN_CYCLE > 1) ? $clog2(DRAIN_CYCLE) : 1;

  drain_state_e state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [63:0] rx_q, rx_d;
  logic [63:0] lat_q, lat_d;
  logic [15:0] max_q, max_d;
  logic [15:0] derr_q, derr_d;
  logic [15:0] drop_q, drop_d;
  logic        bp_q, bp_d;
  logic        done_q, done_d;

  logic                   valid_in;
  logic                   push;
  logic                   pop;
  logic [PACKET_SIZE-1:0] rdata;
  logic [CW-1:0]          count_nx;
  logic                   full;
  logic                   empty;
  logic [15:0]            lat;
  logic [15:0]            dst;
  logic                   unused_src;

  assign valid_in = eject_in[VALID_BIT];
  // A full FIFO still takes an arrival when a slot frees this cycle.
  assign push     = valid_in && (!full || pop);

  eject_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wdata      (eject_in),
    .rdata      (rdata),
    .count_next (count_nx),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Transitions look at the post-update count so a packet pushed now
  // is popped next cycle, never in the same one.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (count_nx != '0 && gap_q == '0) state_d = ST_POP;
      end
      ST_POP: begin
        if (DRAIN_CYCLE > 1) begin
          state_d = ST_WAIT;
          gap_d   = GW'(DRAIN_CYCLE - 1);
        end else if (count_nx == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) begin
          state_d = (count_nx != '0) ? ST_POP : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  always_comb begin
    pop = (state_q == ST_POP) && !empty;
  end

  assign lat        = clk_counter - rdata[TS_MSB:TS_LSB];
  assign dst        = rdata[DST_MSB:DST_LSB];
  assign unused_src = ^rdata[SRC_MSB:SRC_LSB];

  always_comb begin
    rx_d   = rx_q;
    lat_d  = lat_q;
    max_d  = max_q;
    derr_d = derr_q;
    drop_d = drop_q;
    if (pop) begin
      rx_d  = rx_q + 64'd1;
      lat_d = lat_q + {48'd0, lat};
      if (lat > max_q) max_d = lat;
      if (dst != 16'(ROUTER_ID) && derr_q != 16'hFFFF) begin
        derr_d = derr_q + 16'd1;
      end
    end
    if (valid_in && !push && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
    bp_d   = (BUFFER_SIZE - int'(count_nx)) < BUFFER_THRESHOLD;
    done_d = done_q || (rx_q == 64'(EXPECTED_PACKETS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q   <= '0;
      lat_q  <= '0;
      max_q  <= '0;
      derr_q <= '0;
      drop_q <= '0;
      bp_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rx_q   <= rx_d;
      lat_q  <= lat_d;
      max_q  <= max_d;
      derr_q <= derr_d;
      drop_q <= drop_d;
      bp_q   <= bp_d;
      done_q <= done_d;
    end
  end

  assign backpressure_wr      = bp_q;
  assign total_packet_recieve = rx_q;
  assign total_latency        = lat_q;
  assign max_latency          = max_q;
  assign dest_error_cnt       = derr_q;
  assign drop_cnt             = drop_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_packet_eject_local.sv
// Bench for packet_eject_local: three instances with drain gaps 2, 1, 4
// share one stimulus stream and are checked against a queue-level model.
module tb_packet_eject_local;

  localparam int N = 3;
  localparam int DCS[N] = '{2, 1, 4};

  logic        clk;
  logic        rst;
  logic [15:0] clk_counter;
  logic [48:0] eject_in;

  logic        bp   [N];
  logic [63:0] rx   [N];
  logic [63:0] tlat [N];
  logic [15:0] mx   [N];
  logic [15:0] derr [N];
  logic [15:0] drop [N];
  logic        dn   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    packet_eject_local #(
      .DRAIN_CYCLE (DCS[g])
    ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .clk_counter          (clk_counter),
      .eject_in             (eject_in),
      .backpressure_wr      (bp[g]),
      .total_packet_recieve (rx[g]),
      .total_latency        (tlat[g]),
      .max_latency          (mx[g]),
      .dest_error_cnt       (derr[g]),
      .drop_cnt             (drop[g]),
      .done                 (dn[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: an ordered list per instance, a pop allowed once
  // the list is non-empty and DRAIN_CYCLE cycles have passed.
  logic [48:0] m_q    [N][4];
  int          m_n    [N];
  longint      m_last [N];
  logic [63:0] m_rx   [N];
  logic [63:0] m_lat  [N];
  logic [15:0] m_max  [N];
  logic [15:0] m_derr [N];
  logic [15:0] m_drop [N];
  logic        m_bp   [N];
  logic        m_done [N];

  logic [15:0] cc;
  longint      t;

  function automatic logic [177:0] got_v(int i);
    return {bp[i], dn[i], rx[i], tlat[i], mx[i], derr[i], drop[i]};
  endfunction

  function automatic logic [177:0] exp_v(int i);
    return {m_bp[i], m_done[i], m_rx[i], m_lat[i],
            m_max[i], m_derr[i], m_drop[i]};
  endfunction

  task automatic model_cycle(input logic r, input logic [48:0] pkt);
    logic [48:0] p;
    logic [15:0] l;
    logic        dnew;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_n[i] = 0; m_last[i] = -1000;
        m_rx[i] = 0; m_lat[i] = 0; m_max[i] = 0;
        m_derr[i] = 0; m_drop[i] = 0;
        m_bp[i] = 0; m_done[i] = 0;
        continue;
      end
      dnew = m_done[i] || (m_rx[i] == 64'd20);
      if (m_n[i] > 0 && t >= m_last[i] + DCS[i]) begin
        p = m_q[i][0];
        for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
        m_n[i]--;
        l = cc - p[47:32];
        m_rx[i]++;
        m_lat[i] += 64'(l);
        if (l > m_max[i]) m_max[i] = l;
        if (p[15:0] != 16'd0 && m_derr[i] != 16'hFFFF) m_derr[i]++;
        m_last[i] = t;
      end
      if (pkt[48]) begin
        if (m_n[i] < 4) begin
          m_q[i][m_n[i]] = pkt;
          m_n[i]++;
        end else if (m_drop[i] != 16'hFFFF) begin
          m_drop[i]++;
        end
      end
      m_bp[i]   = (4 - m_n[i]) < 1;
      m_done[i] = dnew;
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [15:0] ts, input logic [15:0] dst);
    logic [48:0] pkt;
    pkt = {v, ts, 16'($urandom), dst};
    rst = r;
    clk_counter = cc;
    eject_in = pkt;
    model_cycle(r, pkt);
    @(posedge clk);
    #1;
    cc = cc + 16'd1;
    t++;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 16'd3, 16'd0);
    step(1'b1, 1'b1, 16'd3, 16'd0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_v(i) !== 178'd0) begin
        failures++;
        $display("FAIL reset inst%0d got=%h exp=0", i, got_v(i));
      end
    end
  endtask

  task automatic test_latency();
    step(1'b1, 1'b0, 16'd0, 16'd0);
    cc = 16'd99;
    step(1'b0, 1'b1, 16'd90, 16'd0);
    step(1'b0, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tlat[i] !== 64'd10 || rx[i] !== 64'd1 || mx[i] !== 16'd10) begin
        failures++;
        $display("FAIL latency inst%0d got lat=%0d rx=%0d max=%0d exp 10/1/10",
                 i, tlat[i], rx[i], mx[i]);
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 16'd0, 16'd0);
    cc = 16'd4;
    step(1'b0, 1'b1, 16'hFFF0, 16'd0);
    step(1'b0, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tlat[i] !== 64'd21) begin
        failures++;
        $display("FAIL wrap inst%0d got=%0d exp=21", i, tlat[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b0, 16'd0, 16'd0);
    for (int c = 0; c < 14; c++) begin
      step(1'b0, 1'b1, cc - 16'(c), 16'd0);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got_v(i) !== exp_v(i)) begin
          failures++;
          if (failures < 20)
            $display("FAIL bp_cycle%0d inst%0d got=%h exp=%h",
                     c, i, got_v(i), exp_v(i));
        end
      end
    end
    checks++;
    if (drop[2] === 16'd0 || bp[2] !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got drop=%0d bp=%0b exp drop>0 bp=1",
               drop[2], bp[2]);
    end
  endtask

  task automatic test_back_to_back();
    longint pops[$];
    logic [63:0] prev;
    step(1'b1, 1'b0, 16'd0, 16'd0);
    prev = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, c < 4, cc, 16'd0);
      if (rx[0] !== prev) pops.push_back(t);
      prev = rx[0];
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got_v(i) !== exp_v(i)) begin
          failures++;
          if (failures < 20)
            $display("FAIL b2b_cycle%0d inst%0d got=%h exp=%h",
                     c, i, got_v(i), exp_v(i));
        end
      end
    end
    checks++;
    if (pops.size() != 4) begin
      failures++;
      $display("FAIL b2b_pops got=%0d exp=4", pops.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (pops[k] - pops[k-1] != 2) begin
          failures++;
          $display("FAIL b2b_gap%0d got=%0d exp=2", k, pops[k] - pops[k-1]);
        end
      end
    end
  endtask

  task automatic test_dest_done();
    step(1'b1, 1'b0, 16'd0, 16'd0);
    for (int c = 0; c < 110; c++) begin
      step(1'b0, (c % 5 == 0) && (c < 100), cc - 16'd7,
           (c == 25) ? 16'd3 : 16'd0);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got_v(i) !== exp_v(i)) begin
          failures++;
          if (failures < 20)
            $display("FAIL done_cycle%0d inst%0d got=%h exp=%h",
                     c, i, got_v(i), exp_v(i));
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (derr[i] !== 16'd1 || rx[i] !== 64'd20 || dn[i] !== 1'b1) begin
        failures++;
        $display("FAIL done inst%0d got derr=%0d rx=%0d done=%0b exp 1/20/1",
                 i, derr[i], rx[i], dn[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 16'd0, 16'd0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, cc, 16'd0);
    step(1'b1, 1'b1, cc, 16'd0);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got_v(i) !== 178'd0) begin
          failures++;
          if (failures < 20)
            $display("FAIL rst_mid%0d inst%0d got=%h exp=0", c, i, got_v(i));
        end
      end
      step(1'b0, 1'b0, 16'd0, 16'd0);
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 16'd0, 16'd0);
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
           cc - 16'($urandom_range(0, 60)), 16'($urandom_range(0, 3)));
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got_v(i) !== exp_v(i)) begin
          failures++;
          if (failures < 20)
            $display("FAIL rand_cycle%0d inst%0d got=%h exp=%h",
                     c, i, got_v(i), exp_v(i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clk_counter = '0;
    eject_in = '0;
    cc = '0;
    t = 0;
    test_reset();
    test_latency();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_dest_done();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
